// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, instruction memory address, IF/ID pipeline register and BOOT/RUN/HALT control.
// Optional saturating fetch counter enabled by defining FETCH_COUNT_EN.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [63:0] Branch_Target,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_Valid,
    input  logic        IFID_Ready,
`ifdef FETCH_COUNT_EN
    output logic [31:0] Fetch_Count,
`endif
    output logic        Misaligned,
    output logic        Halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        halted_q, halted_d;
    logic        advance_s;

    // Fetch permission: running, not stalled, and IF/ID free or being drained.
    always_comb begin
        advance_s = (state_q == ST_RUN) && !Stall && (!ifid_valid_q || IFID_Ready);
    end

    // Next-state logic; a taken branch outranks stall and halt outside BOOT.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        misaligned_d = misaligned_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (Branch_Taken) begin
                    pc_d         = {Branch_Target[63:2], 2'b00};
                    ifid_valid_d = 1'b0;
                    state_d      = ST_RUN;
                    if (Branch_Target[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                    end else begin
                        misaligned_d = misaligned_q;
                    end
                end else if (advance_s) begin
                    if (Instruction != HALT_WORD) begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = Instruction;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_q + 64'd4;
                    end else begin
                        // Halt word is consumed but never forwarded; a held entry still drains.
                        state_d = ST_HALT;
                        if (IFID_Ready) begin
                            ifid_valid_d = 1'b0;
                        end else begin
                            ifid_valid_d = ifid_valid_q;
                        end
                    end
                end else if (ifid_valid_q && IFID_Ready) begin
                    ifid_valid_d = 1'b0;
                end else begin
                    ifid_valid_d = ifid_valid_q;
                end
            end
            default: begin
                state_d      = ST_BOOT;
                ifid_valid_d = 1'b0;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 64'h0;
            ifid_instr_q <= 32'h0;
            ifid_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            misaligned_q <= misaligned_d;
            halted_q     <= halted_d;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Count accepted IF/ID handoffs, saturating at all-ones.
    always_comb begin
        if (ifid_valid_q && IFID_Ready && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Fetch counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Fetch_Count = fetch_count_q;
`endif

    assign Inst_Address     = pc_q;
    assign IFID_PC          = ifid_pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_Valid       = ifid_valid_q;
    assign Misaligned       = misaligned_q;
    assign Halted           = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench for instruction_fetch_unit with a queue scoreboard of expected IF/ID loads.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic [63:0] inst_addr;
    logic [31:0] instr;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        ifid_ready;
    logic        misaligned;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .Stall            (stall),
        .Branch_Taken     (br),
        .Branch_Target    (tgt),
        .Inst_Address     (inst_addr),
        .Instruction      (instr),
        .IFID_PC          (ifid_pc),
        .IFID_Instruction (ifid_instr),
        .IFID_Valid       (ifid_valid),
        .IFID_Ready       (ifid_ready),
`ifdef FETCH_COUNT_EN
        .Fetch_Count      (fetch_count),
`endif
        .Misaligned       (misaligned),
        .Halted           (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   mem_word = 32'h0285_3483;
            64'h4:   mem_word = 32'h009A_84B3;
            64'h8:   mem_word = 32'h0014_8493;
            64'hC:   mem_word = 32'h0000_0000;
            64'h10:  mem_word = 32'h00A0_0513;
            default: mem_word = {a[31:2], 2'b11} ^ 32'h1234_0000;
        endcase
    endfunction

    assign instr = mem_word(inst_addr);

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic        ready;
        logic [63:0] e_addr;
        logic        e_valid;
        logic        ld;
        logic [63:0] ld_pc;
        logic        e_halt;
        logic        e_mis;
    } vec_t;

    vec_t        tbl1[18];
    vec_t        tbl2[4];
    logic [95:0] sb_q[$];
    logic [95:0] cur_exp;
    int          n_vec;
    int          n_err;

    function automatic vec_t mk(input logic s, input logic b, input logic [63:0] t, input logic r,
                                input logic [63:0] ea, input logic ev, input logic l,
                                input logic [63:0] lp, input logic eh, input logic em);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.ready = r;
        v.e_addr = ea; v.e_valid = ev; v.ld = l; v.ld_pc = lp; v.e_halt = eh; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        stall      = v.stall;
        br         = v.br;
        tgt        = v.tgt;
        ifid_ready = v.ready;
        if (v.ld) sb_q.push_back({v.ld_pc, mem_word(v.ld_pc)});
        @(posedge clk);
        #1;
        chk($sformatf("addr[%0d]", idx), inst_addr, v.e_addr);
        chk($sformatf("valid[%0d]", idx), {63'h0, ifid_valid}, {63'h0, v.e_valid});
        chk($sformatf("halted[%0d]", idx), {63'h0, halted}, {63'h0, v.e_halt});
        chk($sformatf("misaligned[%0d]", idx), {63'h0, misaligned}, {63'h0, v.e_mis});
        if (v.ld) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("sb_empty[%0d]", idx), 64'h1, 64'h0);
            end else begin
                cur_exp = sb_q.pop_front();
            end
        end
        if (v.e_valid) begin
            chk($sformatf("ifid_pc[%0d]", idx), ifid_pc, cur_exp[95:32]);
            chk($sformatf("ifid_instr[%0d]", idx), {32'h0, ifid_instr}, {32'h0, cur_exp[31:0]});
        end
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = 64'h0; ifid_ready = 1'b1;
        n_vec = 0; n_err = 0; cur_exp = 96'h0;

        //            stall br tgt     rdy  addr   vld ld ldpc   halt mis
        tbl1[0]  = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h0,  1'b0, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl1[1]  = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h4,  1'b1, 1'b1, 64'h0,  1'b0, 1'b0);
        tbl1[2]  = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h8,  1'b1, 1'b1, 64'h4,  1'b0, 1'b0);
        tbl1[3]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h8,  1'b1, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl1[4]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 64'h8,  1'b0, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl1[5]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 64'h8,  1'b0, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl1[6]  = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'hC,  1'b1, 1'b1, 64'h8,  1'b0, 1'b0);
        tbl1[7]  = mk(1'b0, 1'b0, 64'h0,  1'b0, 64'hC,  1'b1, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl1[8]  = mk(1'b0, 1'b0, 64'h0,  1'b0, 64'hC,  1'b1, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl1[9]  = mk(1'b1, 1'b1, 64'h10, 1'b0, 64'h10, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl1[10] = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h14, 1'b1, 1'b1, 64'h10, 1'b0, 1'b0);
        tbl1[11] = mk(1'b0, 1'b1, 64'h8,  1'b1, 64'h8,  1'b0, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl1[12] = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'hC,  1'b1, 1'b1, 64'h8,  1'b0, 1'b0);
        tbl1[13] = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'hC,  1'b0, 1'b0, 64'h0,  1'b1, 1'b0);
        tbl1[14] = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'hC,  1'b0, 1'b0, 64'h0,  1'b1, 1'b0);
        tbl1[15] = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'hC,  1'b0, 1'b0, 64'h0,  1'b1, 1'b0);
        tbl1[16] = mk(1'b0, 1'b1, 64'h6,  1'b1, 64'h4,  1'b0, 1'b0, 64'h0,  1'b0, 1'b1);
        tbl1[17] = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h8,  1'b1, 1'b1, 64'h4,  1'b0, 1'b1);

        tbl2[0]  = mk(1'b0, 1'b1, 64'h22, 1'b1, 64'h0,  1'b0, 1'b0, 64'h0,  1'b0, 1'b0);
        tbl2[1]  = mk(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
                      1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        tbl2[2]  = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h0,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
                      1'b0, 1'b0);
        tbl2[3]  = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h4,  1'b1, 1'b1, 64'h0,  1'b0, 1'b0);

        // Reset state while held in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", inst_addr, 64'h0);
        chk("rst_valid", {63'h0, ifid_valid}, 64'h0);
        chk("rst_ifid_pc", ifid_pc, 64'h0);
        chk("rst_ifid_instr", {32'h0, ifid_instr}, 64'h0);
        chk("rst_halted", {63'h0, halted}, 64'h0);
        chk("rst_mis", {63'h0, misaligned}, 64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) apply(tbl1[i], i);

        // Mid-run asynchronous reset at PC=8 with a valid entry; check before any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_addr", inst_addr, 64'h0);
        chk("arst_valid", {63'h0, ifid_valid}, 64'h0);
        chk("arst_ifid_pc", ifid_pc, 64'h0);
        chk("arst_ifid_instr", {32'h0, ifid_instr}, 64'h0);
        chk("arst_mis", {63'h0, misaligned}, 64'h0);
        chk("arst_halted", {63'h0, halted}, 64'h0);
`ifdef FETCH_COUNT_EN
        chk("arst_count", {32'h0, fetch_count}, 64'h0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // BOOT ignores a branch, then PC wraps past the top of the address space.
        for (int i = 0; i < 4; i++) apply(tbl2[i], 100 + i);
`ifdef FETCH_COUNT_EN
        chk("fetch_count", {32'h0, fetch_count}, 64'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
